// File: rtl/tm1638_key_conditioner.sv
// Per-key synchroniser, debouncer and press/release strobe generator for TM1638 keys.
// Optional auto-repeat on key_pressed is enabled by defining TM1638_KEY_AUTOREPEAT_EN.

module tm1638_key_lane #(
    parameter int debounce_cycles = 250000,
    parameter int repeat_delay    = 12500000,
    parameter int repeat_period   = 5000000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic pressed,
    output logic released
);
    localparam int CW = $clog2(debounce_cycles + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(debounce_cycles - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          fire;

    // fire marks the edge on which a differing s2 has been stable long enough
    assign fire = (s2 != level) && (cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (fire) begin
                cnt   <= '0;
                level <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef TM1638_KEY_AUTOREPEAT_EN
    localparam int RMAX = (repeat_delay > repeat_period) ? repeat_delay : repeat_period;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(repeat_delay - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(repeat_period - 1);

    logic [RW-1:0] rpt;
    logic          armed;
    logic          rpt_fire;

    // armed selects between the initial hold delay and the steady repeat period
    assign rpt_fire = level && (rpt == (armed ? PERIOD_LAST : DELAY_LAST));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rpt   <= '0;
            armed <= 1'b0;
        end else if (!level || fire) begin
            rpt   <= '0;
            armed <= 1'b0;
        end else if (rpt_fire) begin
            rpt   <= '0;
            armed <= 1'b1;
        end else begin
            rpt <= rpt + 1'b1;
        end
    end

    // A release on the same edge wins over a due repeat
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            pressed  <= (fire & s2) | (rpt_fire & ~fire);
            released <= fire & ~s2;
        end
    end
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            pressed  <= fire & s2;
            released <= fire & ~s2;
        end
    end
`endif

endmodule

module tm1638_key_conditioner #(
    parameter int w_key           = 8,
    parameter int debounce_cycles = 250000,
    parameter int repeat_delay    = 12500000,
    parameter int repeat_period   = 5000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [w_key-1:0] key_raw,
    output logic [w_key-1:0] key_level,
    output logic [w_key-1:0] key_pressed,
    output logic [w_key-1:0] key_released,
    output logic             key_any
);
    for (genvar i = 0; i < w_key; i++) begin : g_lane
        tm1638_key_lane #(
            .debounce_cycles (debounce_cycles),
            .repeat_delay    (repeat_delay),
            .repeat_period   (repeat_period)
        ) u_lane (
            .clock    (clock),
            .reset    (reset),
            .raw      (key_raw[i]),
            .level    (key_level[i]),
            .pressed  (key_pressed[i]),
            .released (key_released[i])
        );
    end

    assign key_any = |key_level;

endmodule

// File: tb/tb_tm1638_key_conditioner.sv
// Scoreboard bench: stimulus queues expected strobe events, a monitor pops them as strobes appear.

module tb_tm1638_key_conditioner;
    logic       clock;
    logic       reset;
    logic [7:0] key_raw;
    logic [7:0] key_level;
    logic [7:0] key_pressed;
    logic [7:0] key_released;
    logic       key_any;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    typedef struct {
        int         edge_no;
        logic [7:0] pressed;
        logic [7:0] released;
        logic [7:0] level;
    } ev_t;
    ev_t expq[$];

    tm1638_key_conditioner #(
        .w_key(8), .debounce_cycles(4), .repeat_delay(20), .repeat_period(8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .key_raw      (key_raw),
        .key_level    (key_level),
        .key_pressed  (key_pressed),
        .key_released (key_released),
        .key_any      (key_any)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // Monitor: every strobe cycle must match the head of the expectation queue
    always @(negedge clock) begin
        if (key_pressed != 8'h00 || key_released != 8'h00) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe edge=%0d pressed=%h released=%h required no strobe",
                         edge_cnt, key_pressed, key_released);
            end else begin
                ev_t e;
                e = expq.pop_front();
                if (edge_cnt != e.edge_no || key_pressed != e.pressed ||
                    key_released != e.released || key_level != e.level) begin
                    errors++;
                    $display("FAIL strobe edge=%0d pressed=%h released=%h level=%h required edge=%0d pressed=%h released=%h level=%h",
                             edge_cnt, key_pressed, key_released, key_level,
                             e.edge_no, e.pressed, e.released, e.level);
                end
            end
        end
    end

    function automatic void push(int e, logic [7:0] p, logic [7:0] r, logic [7:0] l);
        ev_t ev;
        ev.edge_no = e; ev.pressed = p; ev.released = r; ev.level = l;
        expq.push_back(ev);
    endfunction

    task automatic step(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(string name, logic [7:0] act, logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drain(string name);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL %s missing_strobes actual=%0d required=0 (next edge %0d)",
                     name, expq.size(), expq[0].edge_no);
            expq.delete();
        end
    endtask

    initial begin
        int k;
        key_raw = 8'h00;
        reset   = 1'b1;
        step(3);
        check("reset_level", key_level, 8'h00);
        check("reset_pressed", key_pressed, 8'h00);
        check("reset_any", {7'b0, key_any}, 8'h00);
        reset = 1'b0;
        step(20);
        check("idle_level", key_level, 8'h00);
        check("idle_any", {7'b0, key_any}, 8'h00);
        drain("idle");

        // single key press: level and strobe at edge 6
        k = edge_cnt;
        key_raw = 8'h01;
        push(k + 6, 8'h01, 8'h00, 8'h01);
        step(5);
        check("k0_level_e5", key_level, 8'h00);
        check("k0_any_e5", {7'b0, key_any}, 8'h00);
        step(1);
        check("k0_level_e6", key_level, 8'h01);
        check("k0_any_e6", {7'b0, key_any}, 8'h01);
        step(4);
        k = edge_cnt;
        key_raw = 8'h00;
        push(k + 6, 8'h00, 8'h01, 8'h00);
        step(10);
        check("k0_released_level", key_level, 8'h00);
        drain("k0");

        // bounce on key 3, then hold
        key_raw = 8'h08; step(1);
        key_raw = 8'h00; step(1);
        key_raw = 8'h08; step(1);
        key_raw = 8'h00; step(1);
        key_raw = 8'h08;
        k = edge_cnt;
        push(k + 6, 8'h08, 8'h00, 8'h08);
        step(5);
        check("k3_level_e5", key_level, 8'h00);
        step(1);
        check("k3_level_e6", key_level, 8'h08);
        step(4);
        k = edge_cnt;
        key_raw = 8'h00;
        push(k + 6, 8'h00, 8'h08, 8'h00);
        step(10);
        drain("k3");

        // short pulse on key 2 is rejected
        key_raw = 8'h04;
        step(3);
        key_raw = 8'h00;
        step(12);
        check("k2_glitch_level", key_level, 8'h00);
        drain("k2");

        // simultaneous keys 7 and 0
        k = edge_cnt;
        key_raw = 8'h81;
        push(k + 6, 8'h81, 8'h00, 8'h81);
        step(10);
        check("k81_level", key_level, 8'h81);
        k = edge_cnt;
        key_raw = 8'h00;
        push(k + 6, 8'h00, 8'h81, 8'h00);
        step(10);
        drain("k81");

        // reset while key 5 is held
        k = edge_cnt;
        key_raw = 8'h20;
        push(k + 6, 8'h20, 8'h00, 8'h20);
        step(8);
        check("k5_level_before_rst", key_level, 8'h20);
        reset = 1'b1;
        #1;
        check("k5_rst_level", key_level, 8'h00);
        check("k5_rst_any", {7'b0, key_any}, 8'h00);
        step(1);
        reset = 1'b0;
        k = edge_cnt;
        push(k + 6, 8'h20, 8'h00, 8'h20);
        step(10);
        k = edge_cnt;
        key_raw = 8'h00;
        push(k + 6, 8'h00, 8'h20, 8'h00);
        step(10);
        drain("k5");

        // key 1 held 60 cycles; release lands where a repeat would be due
        k = edge_cnt;
        key_raw = 8'h02;
        push(k + 6, 8'h02, 8'h00, 8'h02);
`ifdef TM1638_KEY_AUTOREPEAT_EN
        push(k + 26, 8'h02, 8'h00, 8'h02);
        push(k + 34, 8'h02, 8'h00, 8'h02);
        push(k + 42, 8'h02, 8'h00, 8'h02);
        push(k + 50, 8'h02, 8'h00, 8'h02);
        push(k + 58, 8'h02, 8'h00, 8'h02);
`endif
        step(60);
        key_raw = 8'h00;
        push(k + 66, 8'h00, 8'h02, 8'h00);
        step(20);
        check("k1_final_level", key_level, 8'h00);
        drain("k1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
